// File: rtl/pipe_pkg.sv
// Shared constants for the MIPS pipeline stage registers: fill-level encoding,
// per-stage payload/control widths and per-stage bubble control values.
package pipe_pkg;

  localparam logic [1:0] CNT_EMPTY = 2'd0;
  localparam logic [1:0] CNT_ONE   = 2'd1;
  localparam logic [1:0] CNT_FULL  = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY = CNT_EMPTY,
    ST_ONE   = CNT_ONE,
    ST_FULL  = CNT_FULL
  } fill_e;

  localparam int IFID_DATA_W  = 96;
  localparam int IFID_CTRL_W  = 2;
  localparam int IDEX_DATA_W  = 128;
  localparam int IDEX_CTRL_W  = 16;
  localparam int EXMEM_DATA_W = 104;
  localparam int EXMEM_CTRL_W = 8;
  localparam int MEMWB_DATA_W = 104;
  localparam int MEMWB_CTRL_W = 4;

  localparam logic [IFID_CTRL_W-1:0]  IFID_CTRL_RST  = '0;
  localparam logic [IDEX_CTRL_W-1:0]  IDEX_CTRL_RST  = '0;
  localparam logic [EXMEM_CTRL_W-1:0] EXMEM_CTRL_RST = '0;
  localparam logic [MEMWB_CTRL_W-1:0] MEMWB_CTRL_RST = '0;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle between two pipeline stages; the producer side
// drives valid/data/ctrl through the master modport, the consumer drives ready.
interface pipe_stage_reg_if #(
  parameter int DATA_W = pipe_pkg::IDEX_DATA_W,
  parameter int CTRL_W = pipe_pkg::IDEX_CTRL_W
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input  ready);
  modport slave  (input  valid, input  data, input  ctrl, output ready);
endinterface

// File: rtl/pipe_entry_reg.sv
// One data+control holding register with synchronous clear (priority) and load.
module pipe_entry_reg #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl
);

  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      data_q <= '0;
      ctrl_q <= '0;
    end else if (i_clear) begin
      data_q <= '0;
      ctrl_q <= '0;
    end else if (i_load) begin
      data_q <= i_data;
      ctrl_q <= i_ctrl;
    end
  end

  assign o_data = data_q;
  assign o_ctrl = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with flush, debug step gating and bubble
// masking of control. Define PIPE_SKID_EN for the 2-entry skid / registered-ready build.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = IDEX_DATA_W,
  parameter int                CTRL_W   = IDEX_CTRL_W,
  parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_flush,
  input  logic                 i_step,
  pipe_stage_reg_if.slave      up,
  pipe_stage_reg_if.master     dn,
  output logic [1:0]           o_count
);

  fill_e             state_q, state_d;
  logic              accept, rel;
  logic              main_load;
  logic [DATA_W-1:0] main_din, main_data;
  logic [CTRL_W-1:0] main_cin, main_ctrl;

`ifdef PIPE_SKID_EN
  logic              skid_load, main_from_skid, ready_q;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
`endif

  assign accept   = up.valid & up.ready & i_step & ~i_flush;
  assign rel      = dn.valid & dn.ready & i_step;
  assign dn.valid = (state_q != ST_EMPTY);
  assign dn.data  = main_data;
  assign dn.ctrl  = dn.valid ? main_ctrl : CTRL_RST;
  assign o_count  = state_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state_q <= ST_EMPTY;
    else          state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
`ifdef PIPE_SKID_EN
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
`endif
    if (i_flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) begin
          state_d   = ST_ONE;
          main_load = 1'b1;
        end
        ST_ONE: begin
          if (accept) begin
`ifdef PIPE_SKID_EN
            if (rel) begin
              main_load = 1'b1;
            end else begin
              state_d   = ST_FULL;
              skid_load = 1'b1;
            end
`else
            main_load = 1'b1;
`endif
          end else if (rel) begin
            state_d = ST_EMPTY;
          end
        end
`ifdef PIPE_SKID_EN
        ST_FULL: if (rel) begin
          state_d        = ST_ONE;
          main_load      = 1'b1;
          main_from_skid = 1'b1;
        end
`endif
        default: state_d = ST_EMPTY;
      endcase
    end
  end

`ifdef PIPE_SKID_EN
  // Ready comes from a flop so i_ready never reaches o_ready combinationally.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) ready_q <= 1'b1;
    else          ready_q <= (state_d != ST_FULL);
  end

  assign up.ready = ready_q & i_step;
  assign main_din = main_from_skid ? skid_data : up.data;
  assign main_cin = main_from_skid ? skid_ctrl : up.ctrl;

  pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (i_flush),
    .i_load  (skid_load),
    .i_data  (up.data),
    .i_ctrl  (up.ctrl),
    .o_data  (skid_data),
    .o_ctrl  (skid_ctrl)
  );
`else
  assign up.ready = i_step & ~i_flush & (~dn.valid | dn.ready);
  assign main_din = up.data;
  assign main_cin = up.ctrl;
`endif

  pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (i_flush),
    .i_load  (main_load),
    .i_data  (main_din),
    .i_ctrl  (main_cin),
    .o_data  (main_data),
    .o_ctrl  (main_ctrl)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations; adapts to PIPE_SKID_EN.
module tb_pipe_stage_reg;

  localparam int             DW   = 16;
  localparam int             CW   = 8;
  localparam logic [CW-1:0]  CRST = 8'h5A;

  logic       clk = 1'b0;
  logic       rst_n, flush, step;
  logic [1:0] count;

  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) up_if ();
  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) dn_if ();

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_RST(CRST)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .i_flush (flush),
    .i_step  (step),
    .up      (up_if),
    .dn      (dn_if),
    .o_count (count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of held entries plus the last payload shown.
  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  ent_t          q[$];
  logic [DW-1:0] last_d = '0;
  logic          m_acc, m_rel;

  function automatic logic m_ready();
`ifdef PIPE_SKID_EN
    return step && (q.size() < 2);
`else
    return step && !flush && (q.size() == 0 || dn_if.ready);
`endif
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n || flush) begin
      q.delete();
      last_d = '0;
    end else if (step) begin
      m_acc = up_if.valid && m_ready();
      m_rel = (q.size() != 0) && dn_if.ready;
      if (m_rel) begin
        last_d = q[0].d;
        void'(q.pop_front());
      end
      if (m_acc) q.push_back({up_if.data, up_if.ctrl});
    end
  end

  initial forever begin
    @(negedge clk);
    check("cmp_count", 32'(count), 32'(q.size()));
    check("cmp_valid", 32'(dn_if.valid), 32'(q.size() != 0));
    check("cmp_ready", 32'(up_if.ready), 32'(m_ready()));
    check("cmp_data", 32'(dn_if.data), 32'((q.size() != 0) ? q[0].d : last_d));
    check("cmp_ctrl", 32'(dn_if.ctrl), 32'((q.size() != 0) ? q[0].c : CRST));
  end

  task automatic apply(input logic v, input logic [DW-1:0] d, input logic r,
                       input logic s, input logic f);
    up_if.valid = v;
    up_if.data  = d;
    up_if.ctrl  = d[7:0] ^ 8'hC3;
    dn_if.ready = r;
    step        = s;
    flush       = f;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic r,
                       input logic s, input logic f);
    @(posedge clk);
    #1;
    apply(v, d, r, s, f);
  endtask

  initial begin
    rst_n = 1'b1;
    apply(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(dn_if.valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ctrl", 32'(dn_if.ctrl), 32'(CRST));
    check("rst_data", 32'(dn_if.data), 32'd0);
    check("rst_ready", 32'(up_if.ready), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Streaming: one entry per cycle, presented one cycle after acceptance.
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 16'(i), 1'b1, 1'b1, 1'b0);
      if (i > 1) begin
        @(negedge clk);
        check("stream_data", 32'(dn_if.data), 32'(i - 1));
        check("stream_count", 32'(count), 32'd1);
      end
    end
    drive(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("stream_last", 32'(dn_if.data), 32'd6);
    drive(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("drain_valid", 32'(dn_if.valid), 32'd0);
    check("drain_hold", 32'(dn_if.data), 32'd6);
    check("drain_ctrl", 32'(dn_if.ctrl), 32'(CRST));

`ifdef PIPE_SKID_EN
    // Backpressure fills the skid; the third offer waits until space frees up.
    drive(1'b1, 16'hA, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 16'hB, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 16'hC, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("bp_count", 32'(count), 32'd2);
    check("bp_ready", 32'(up_if.ready), 32'd0);
    check("bp_head", 32'(dn_if.data), 32'hA);
    drive(1'b1, 16'hC, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("bp_out_a", 32'(dn_if.data), 32'hA);
    drive(1'b1, 16'hC, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("bp_out_b", 32'(dn_if.data), 32'hB);
    check("bp_ready_back", 32'(up_if.ready), 32'd1);
    drive(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("bp_out_c", 32'(dn_if.data), 32'hC);
    drive(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
`else
    // Ready follows i_ready within the same cycle while an entry is presented.
    drive(1'b1, 16'hA, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 16'hB, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("mirror_low", 32'(up_if.ready), 32'd0);
    check("mirror_head", 32'(dn_if.data), 32'hA);
    drive(1'b1, 16'hB, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("mirror_high", 32'(up_if.ready), 32'd1);
    drive(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("mirror_next", 32'(dn_if.data), 32'hB);
    check("mirror_count", 32'(count), 32'd1);
    drive(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
`endif

    // Flush with the stage occupied and a new entry on offer.
    drive(1'b1, 16'h11, 1'b0, 1'b1, 1'b0);
`ifdef PIPE_SKID_EN
    drive(1'b1, 16'h12, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 16'hD, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("pre_flush_count", 32'(count), 32'd2);
`else
    drive(1'b1, 16'hD, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("pre_flush_count", 32'(count), 32'd1);
`endif
    drive(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("flush_count", 32'(count), 32'd0);
    check("flush_valid", 32'(dn_if.valid), 32'd0);
    check("flush_ctrl", 32'(dn_if.ctrl), 32'(CRST));
    check("flush_data", 32'(dn_if.data), 32'd0);
    drive(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("flush_no_d", 32'(dn_if.valid), 32'd0);

    // Step freeze: nothing moves for five cycles, then one release per cycle.
    drive(1'b1, 16'h21, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'h22, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      check("freeze_data", 32'(dn_if.data), 32'h21);
      check("freeze_count", 32'(count), 32'd1);
      check("freeze_ready", 32'(up_if.ready), 32'd0);
    end
    drive(1'b1, 16'h22, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("resume_ready", 32'(up_if.ready), 32'd1);
    drive(1'b1, 16'h23, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("resume_22", 32'(dn_if.data), 32'h22);
    drive(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("resume_23", 32'(dn_if.data), 32'h23);
    drive(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);

    // Flush must win even while the stage is frozen.
    drive(1'b1, 16'h31, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("frz_flush_count", 32'(count), 32'd0);
    check("frz_flush_data", 32'(dn_if.data), 32'd0);

    // Asynchronous reset in the middle of a cycle with the stage occupied.
    drive(1'b1, 16'h41, 1'b0, 1'b1, 1'b0);
`ifdef PIPE_SKID_EN
    drive(1'b1, 16'h42, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("pre_rst_count", 32'(count), 32'd2);
`else
    drive(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("pre_rst_count", 32'(count), 32'd1);
`endif
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(dn_if.valid), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_ctrl", 32'(dn_if.ctrl), 32'(CRST));
    check("mid_rst_data", 32'(dn_if.data), 32'd0);
    check("mid_rst_ready", 32'(up_if.ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply(1'b1, 16'h51, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("post_rst_valid", 32'(dn_if.valid), 32'd1);
    check("post_rst_data", 32'(dn_if.data), 32'h51);
    drive(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
